mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding memory port.
// Data wins contention until MAX_D_STREAK consecutive data grants have starved fetch.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MAX_D_STREAK   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [MEM_ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t                    state, state_nxt;
  logic [3:0]                streak;
  logic                      streak_full;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  assign streak_full = (streak == STREAK_MAX);

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        // Grants are never issued while reset is asserted.
        if (!rst) begin
          if (d_req && !(if_req && streak_full)) begin
            d_gnt     = 1'b1;
            state_nxt = BUSY_D;
          end else if (if_req) begin
            if_gnt    = 1'b1;
            state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en    = (state != IDLE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (if_gnt) begin
        addr_q <= if_addr;
        we_q   <= 1'b0;
        streak <= '0;
      end else if (d_gnt) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
        // Only count grants that actually made fetch wait.
        if (!if_req)          streak <= '0;
        else if (!streak_full) streak <= streak + 4'd1;
      end
      if (mem_en && mem_ready) begin
        if (state == BUSY_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model,
// with directed scenarios pinning the model to hand-computed values.
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Model: the outstanding access (at most one) plus what the requesters last saw.
  typedef struct { bit fetch; logic [AW-1:0] addr; bit we; } txn_t;
  txn_t          q[$];
  int            m_streak;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
  bit            m_if_rv, m_d_rv;
  bit            e_if_gnt, e_d_gnt;

  task automatic model_reset();
    q.delete();
    m_streak = 0; m_addr = '0; m_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_if_rv = 0; m_d_rv = 0;
  endtask

  task automatic check_model();
    bit idle;
    idle = (q.size() == 0);
    e_if_gnt = 0; e_d_gnt = 0;
    if (!rst && idle) begin
      // Fetch wins when data is absent or data has used its whole streak.
      if (if_req && (!d_req || m_streak == MAXS)) e_if_gnt = 1;
      else if (d_req) e_d_gnt = 1;
    end
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("mem_en", mem_en, !idle);
    chk("mem_we", mem_we, !idle && q[0].we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rvalid", if_rvalid, m_if_rv);
    chk("d_rvalid", d_rvalid, m_d_rv);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
  endtask

  task automatic update_model();
    txn_t t;
    if (rst) begin
      model_reset();
      return;
    end
    m_if_rv = 0; m_d_rv = 0;
    if (q.size() != 0 && mem_ready) begin
      t = q.pop_front();
      if (t.fetch) begin m_if_rv = 1; m_if_rdata = mem_rdata; end
      else begin m_d_rv = 1; m_d_rdata = t.we ? '0 : mem_rdata; end
    end
    if (e_if_gnt) begin
      q.push_back('{fetch: 1'b1, addr: if_addr, we: 1'b0});
      m_addr = if_addr; m_streak = 0;
    end
    if (e_d_gnt) begin
      q.push_back('{fetch: 1'b0, addr: d_addr, we: d_we});
      m_addr = d_addr; m_wdata = d_wdata;
      m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
    end
  endtask

  // Called at negedge+1 with inputs settled; leaves time at the next negedge.
  task automatic tick();
    check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  int seq[$];
  int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0;
    d_wdata = '0; mem_ready = 0; mem_rdata = '0;
    model_reset();
    @(posedge clk); @(negedge clk);

    // Reset state
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    tick();
    rst = 0;

    // Single fetch
    if_req = 1; if_addr = 32'h100; #1;
    chk("f_gnt_c0", if_gnt, 1);
    tick();
    if_req = 0; mem_ready = 1; mem_rdata = 32'h00500093; #1;
    chk("f_en_c1", mem_en, 1);
    chk("f_addr_c1", mem_addr, 32'h100);
    tick();
    mem_ready = 0; mem_rdata = 32'hFFFF_FFFF; #1;
    chk("f_rvalid_c2", if_rvalid, 1);
    chk("f_rdata_c2", if_rdata, 32'h00500093);
    tick();

    // Store with 3-cycle stall
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; #1;
    chk("s_gnt_c0", d_gnt, 1);
    tick();
    d_req = 0; d_we = 0;
    for (int c = 1; c <= 3; c++) begin
      mem_ready = (c == 3); mem_rdata = 32'h5555_5555; #1;
      chk("s_en", mem_en, 1);
      chk("s_we", mem_we, 1);
      chk("s_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_no_rvalid", d_rvalid, 0);
      tick();
    end
    mem_ready = 0; #1;
    chk("s_rvalid_c4", d_rvalid, 1);
    chk("s_rdata_c4", d_rdata, 0);
    chk("s_en_c4", mem_en, 0);
    tick();

    // Contention: both held, memory always ready
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400; mem_ready = 1;
    for (int c = 0; c < 20; c++) begin
      mem_rdata = $urandom; #1;
      chk("cont_one_gnt", if_gnt & d_gnt, 0);
      if (d_gnt) seq.push_back(1);
      else if (if_gnt) seq.push_back(0);
      tick();
    end
    chk("cont_count", seq.size(), 10);
    for (int i = 0; i < 10 && i < seq.size(); i++) chk("cont_order", seq[i], exp_seq[i]);
    if_req = 0; d_req = 0;
    for (int c = 0; c < 3; c++) begin #1; tick(); end

    // Reset in the middle of a stalled load
    d_req = 1; d_we = 0; d_addr = 32'h40; #1;
    chk("r_gnt_c0", d_gnt, 1);
    tick();
    d_req = 0; mem_ready = 0; #1; tick();
    rst = 1; mem_ready = 1; #1; tick();
    rst = 0; #1;
    chk("r_en_c3", mem_en, 0);
    chk("r_rvalid_c3", d_rvalid, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1; chk("r_no_rvalid", d_rvalid, 0); tick();
    end
    if_req = 1; if_addr = 32'h200; #1;
    chk("r_fgnt", if_gnt, 1);
    tick();
    if_req = 0; mem_ready = 1; mem_rdata = 32'h1234; #1; tick();
    #1;
    chk("r_frvalid", if_rvalid, 1);
    chk("r_frdata", if_rdata, 32'h1234);
    tick();

    // Back-to-back loads
    d_req = 1; d_we = 0; d_addr = 32'h1000; mem_ready = 1;
    for (int c = 0; c < 8; c++) begin
      mem_rdata = 32'hA000 + 32'(c); #1;
      chk("b2b_gnt", d_gnt, (c % 2) == 0);
      if (c >= 2) chk("b2b_rvalid", d_rvalid, (c % 2) == 0);
      if (c >= 2 && (c % 2) == 0) chk("b2b_rdata", d_rdata, 32'hA000 + 32'(c - 1));
      tick();
      if (e_d_gnt) d_addr = d_addr + 32'd4;
    end
    d_req = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin if_req = 1; if_addr = $urandom; end
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      mem_ready = $urandom_range(0, 2) != 0;
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 80) == 0);
      #1;
      tick();
      if (e_if_gnt) if_req = 0;
      if (e_d_gnt) d_req = 0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
